// File: rtl/dm_store_rmw_pkg.sv
// Shared definitions for the store read-modify-write block: op codes, FSM states,
// lane-select constants and the alignment/legality check.
package dm_store_rmw_pkg;

    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SH  = 2'b01,
        OP_SB  = 2'b10,
        OP_RSV = 2'b11
    } store_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StMrg,
        StWr,
        StErr
    } state_e;

    // Byte lane within a word, taken from addr[1:0].
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    // Halfword select, taken from addr[1].
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // True when a store must be rejected: reserved op or misaligned address.
    function automatic logic store_rejected(input store_op_e op, input logic [1:0] lane);
        logic rej;
        case (op)
            OP_SW:   rej = (lane != LANE_B0);
            OP_SH:   rej = lane[0];
            OP_SB:   rej = 1'b0;
            default: rej = 1'b1;
        endcase
        return rej;
    endfunction

endpackage

// File: rtl/dm_store_rmw_if.sv
// CPU-side store request bus: request/op/address/data in, ready/done/err back.
interface dm_store_rmw_if;

    logic        req;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;

    modport master (
        output req, op, addr, wdata,
        input  ready, done, err
    );

    modport slave (
        input  req, op, addr, wdata,
        output ready, done, err
    );

endinterface

// File: rtl/store_lane_merge.sv
// Combinational merge of new store data into an old memory word.
// sb replaces one byte lane, sh one halfword, sw the whole word.
module store_lane_merge
    import dm_store_rmw_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  store_op_e   op,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    // Start from the old word and overwrite only the lanes the op targets.
    always_comb begin
        merged = old_word;
        case (op)
            OP_SW: merged = new_data;
            OP_SH: begin
                unique case (lane[1])
                    HALF_LO: merged[15:0]  = new_data[15:0];
                    HALF_HI: merged[31:16] = new_data[15:0];
                endcase
            end
            OP_SB: begin
                unique case (lane)
                    LANE_B0: merged[7:0]   = new_data[7:0];
                    LANE_B1: merged[15:8]  = new_data[7:0];
                    LANE_B2: merged[23:16] = new_data[7:0];
                    LANE_B3: merged[31:24] = new_data[7:0];
                endcase
            end
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/dm_store_rmw.sv
// Store unit for a word-only data memory. sw writes directly one cycle after
// accept; sh/sb read the word, merge the new lane(s) and write it back three
// cycles after accept. Illegal stores pulse err and never touch memory.
module dm_store_rmw
    import dm_store_rmw_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    dm_store_rmw_if.slave     bus,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    state_e             state_q, state_d;
    store_op_e          op_q, op_d;
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        data_q, data_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_re_q, mem_re_d;
    logic               mem_we_q, mem_we_d;
    logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        merged_word;
    store_op_e          req_op;

    // Address bits beyond the memory's reach are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:MEM_AW+2];

    assign req_op = store_op_e'(bus.op);

    // mem_rdata is valid during MRG; merge it straight into the write data.
    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .new_data (data_q),
        .op       (op_q),
        .lane     (lane_q),
        .merged   (merged_word)
    );

    // State and registered outputs; reset abandons any store in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= OP_SW;
            lane_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state plus next value of every output, so outputs track the state register.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        data_d      = data_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (bus.req && ready_q) begin
                    ready_d = 1'b0;
                    if (store_rejected(req_op, bus.addr[1:0])) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        // mem_addr only moves on a legal accept, so it stays put RD..WR.
                        op_d       = req_op;
                        lane_d     = bus.addr[1:0];
                        data_d     = bus.wdata;
                        mem_addr_d = bus.addr[MEM_AW+1:2];
                        if (req_op == OP_SW) begin
                            state_d     = StWr;
                            mem_we_d    = 1'b1;
                            done_d      = 1'b1;
                            mem_wdata_d = bus.wdata;
                        end else begin
                            state_d  = StRd;
                            mem_re_d = 1'b1;
                        end
                    end
                end
            end
            StRd: begin
                state_d = StMrg;
            end
            StMrg: begin
                state_d     = StWr;
                mem_we_d    = 1'b1;
                done_d      = 1'b1;
                mem_wdata_d = merged_word;
            end
            StWr: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
            StErr: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_store_rmw.sv
// Self-checking bench for dm_store_rmw: directed vector table, hand-written
// reset/back-to-back sequences and a randomized run against a byte-level model.
module tb_dm_store_rmw;

    localparam int MEM_AW = 10;
    localparam int WORDS  = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    dm_store_rmw_if bus ();

    dm_store_rmw #(.MEM_AW(MEM_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    // Synchronous data memory with a bench-side preload port.
    logic [31:0]       mem [WORDS];
    logic              pre_en = 1'b0;
    logic [MEM_AW-1:0] pre_idx;
    logic [31:0]       pre_data;
    logic [31:0]       ref_mem [WORDS];

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_idx  = idx[MEM_AW-1:0];
        pre_data = data;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Issue one store and record the cycle (1 = first cycle after accept) of each event.
    task automatic run_store(input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata,
                             output int re_cyc, output int we_cyc, output int done_cyc,
                             output int err_cyc, output int rdy_cyc,
                             output logic [31:0] we_data, output logic [31:0] we_addr);
        re_cyc = -1; we_cyc = -1; done_cyc = -1; err_cyc = -1; rdy_cyc = -1;
        we_data = '0; we_addr = '0;
        @(negedge clk);
        bus.req = 1'b1; bus.op = op; bus.addr = addr; bus.wdata = wdata;
        @(posedge clk);
        #1 bus.req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (mem_re && re_cyc < 0) re_cyc = k;
            if (mem_we && we_cyc < 0) begin
                we_cyc = k; we_data = mem_wdata; we_addr = 32'(mem_addr);
            end
            if (bus.done && done_cyc < 0) done_cyc = k;
            if (bus.err && err_cyc < 0) err_cyc = k;
            if (bus.ready) begin
                rdy_cyc = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: word after a store, built from byte masks.
    function automatic logic [31:0] ref_store(input logic [1:0] op, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [31:0] old);
        int sh;
        logic [31:0] mask;
        case (op)
            2'd0: return wdata;
            2'd1: begin
                sh = 16 * int'((addr >> 1) % 2);
                mask = 32'hFFFF << sh;
                return (old & ~mask) | ((wdata & 32'hFFFF) << sh);
            end
            2'd2: begin
                sh = 8 * int'(addr % 4);
                mask = 32'hFF << sh;
                return (old & ~mask) | ((wdata & 32'hFF) << sh);
            end
            default: return old;
        endcase
    endfunction

    function automatic logic ref_err(input logic [1:0] op, input logic [31:0] addr);
        return (op == 2'd3) || (op == 2'd0 && addr % 4 != 0) || (op == 2'd1 && addr % 2 != 0);
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic        exp_err;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int re_c, we_c, done_c, err_c, rdy_c, widx, mism;
        logic [31:0] we_d, we_a, addr, wdata, exp_word;
        logic [1:0] op;
        logic exp_e;

        vecs[0] = '{2'd0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{2'd2, 32'h0000_0013, 32'h0000_00AA, 32'h1122_3344, 1'b0, 32'hAA22_3344};
        vecs[2] = '{2'd1, 32'h0000_0022, 32'h0000_BEEF, 32'h1122_3344, 1'b0, 32'hBEEF_3344};
        vecs[3] = '{2'd1, 32'h0000_0020, 32'h0000_BEEF, 32'h1122_3344, 1'b0, 32'h1122_BEEF};
        vecs[4] = '{2'd1, 32'h0000_0021, 32'h0000_BEEF, 32'h1122_3344, 1'b1, 32'h1122_3344};
        vecs[5] = '{2'd0, 32'h0000_0022, 32'hDEAD_BEEF, 32'h1122_3344, 1'b1, 32'h1122_3344};
        vecs[6] = '{2'd3, 32'h0000_0030, 32'hDEAD_BEEF, 32'h1122_3344, 1'b1, 32'h1122_3344};
        vecs[7] = '{2'd2, 32'h0000_0034, 32'h1234_56CC, 32'h1122_3344, 1'b0, 32'h1122_33CC};
        vecs[8] = '{2'd2, 32'hFFFF_F035, 32'h0000_0077, 32'h1122_3344, 1'b0, 32'h1122_7744};
        vecs[9] = '{2'd0, 32'h8000_0004, 32'hCAFE_F00D, 32'h5555_5555, 1'b0, 32'hCAFE_F00D};

        bus.req = 1'b0; bus.op = 2'd0; bus.addr = '0; bus.wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.ready), 32'd1);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_mem_re", 32'(mem_re), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            widx = int'((vecs[i].addr >> 2) % WORDS);
            preload(widx, vecs[i].init);
            run_store(vecs[i].op, vecs[i].addr, vecs[i].wdata,
                      re_c, we_c, done_c, err_c, rdy_c, we_d, we_a);
            check($sformatf("vec%0d_err_cycle", i), 32'(err_c), vecs[i].exp_err ? 32'd1 : -32'sd1);
            check($sformatf("vec%0d_done_cycle", i), 32'(done_c),
                  vecs[i].exp_err ? -32'sd1 : (vecs[i].op == 2'd0 ? 32'd1 : 32'd3));
            check($sformatf("vec%0d_re_cycle", i), 32'(re_c),
                  (!vecs[i].exp_err && vecs[i].op != 2'd0) ? 32'd1 : -32'sd1);
            check($sformatf("vec%0d_ready_cycle", i), 32'(rdy_c),
                  (vecs[i].exp_err || vecs[i].op == 2'd0) ? 32'd2 : 32'd4);
            check($sformatf("vec%0d_mem_word", i), mem[widx], vecs[i].exp_word);
            if (!vecs[i].exp_err) begin
                check($sformatf("vec%0d_we_data", i), we_d, vecs[i].exp_word);
                check($sformatf("vec%0d_we_addr", i), we_a, 32'(widx));
            end
        end

        // Reset during MRG of an sb: no write, memory untouched.
        preload(32'h11, 32'h1122_3344);
        @(negedge clk);
        bus.req = 1'b1; bus.op = 2'd2; bus.addr = 32'h47; bus.wdata = 32'hAA;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        we_c = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (mem_we) we_c++;
            if (k == 0) begin
                check("rst_mrg_ready", 32'(bus.ready), 32'd1);
                reset = 1'b0;
            end
        end
        check("rst_mrg_we_count", 32'(we_c), 32'd0);
        check("rst_mrg_mem_word", mem[32'h11], 32'h1122_3344);

        // Reset coincident with the WR edge: the write stands.
        preload(32'h14, 32'h5566_7788);
        @(negedge clk);
        bus.req = 1'b1; bus.op = 2'd2; bus.addr = 32'h50; bus.wdata = 32'h99;
        @(posedge clk);
        #1 bus.req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_wr_we_seen", 32'(mem_we), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_wr_we_after", 32'(mem_we), 32'd0);
        check("rst_wr_mem_word", mem[32'h14], 32'h5566_7799);

        // req held high through an sb: second store only once ready returns.
        preload(32'h18, 32'h0);
        @(negedge clk);
        bus.req = 1'b1; bus.op = 2'd2; bus.addr = 32'h61; bus.wdata = 32'h5A;
        @(posedge clk);
        #1;
        re_c = 0; we_c = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 5) bus.req = 1'b0;
            if (mem_re) re_c++;
            if (mem_we) we_c++;
            @(posedge clk);
            #1;
        end
        check("held_req_re_count", 32'(re_c), 32'd2);
        check("held_req_we_count", 32'(we_c), 32'd2);
        check("held_req_mem_word", mem[32'h18], 32'h0000_5A00);

        // Randomized run against the byte-level model.
        for (int i = 0; i < WORDS; i++) begin
            wdata = $urandom;
            ref_mem[i] = wdata;
            preload(i, wdata);
        end
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op == 2'd0) addr = addr & ~32'h3;
                if (op == 2'd1) addr = addr & ~32'h1;
            end
            wdata = $urandom;
            widx = int'((addr >> 2) % WORDS);
            exp_e = ref_err(op, addr);
            if (!exp_e) ref_mem[widx] = ref_store(op, addr, wdata, ref_mem[widx]);
            exp_word = ref_mem[widx];
            run_store(op, addr, wdata, re_c, we_c, done_c, err_c, rdy_c, we_d, we_a);
            check($sformatf("rnd%0d_err", i), 32'(err_c), exp_e ? 32'd1 : -32'sd1);
            check($sformatf("rnd%0d_done", i), 32'(done_c),
                  exp_e ? -32'sd1 : (op == 2'd0 ? 32'd1 : 32'd3));
            check($sformatf("rnd%0d_word", i), mem[widx], exp_word);
        end
        mism = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("rnd_full_sweep_mismatches", 32'(mism), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
